// File: rtl/wb_region_mux.sv
// Wishbone pipelined region crossbar: one master, NPORTS slaves.
// Drain-before-switch, unmapped-access errors and hung-slave timeout.
module wb_region_mux #(
    parameter int NPORTS = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int REGION_BITS = 4,
    parameter logic [NPORTS*REGION_BITS-1:0] PORT_MAP =
        {4'hf, 4'h7, 4'h3, 4'h0},
    parameter int MAXOUT = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   m_cyc,
    input  logic                   m_stb,
    input  logic                   m_we,
    input  logic [DW/8-1:0]        m_sel,
    input  logic [AW-1:0]          m_adr,
    input  logic [DW-1:0]          m_dat_i,
    output logic [DW-1:0]          m_dat_o,
    output logic                   m_ack,
    output logic                   m_err,
    output logic                   m_stall,
    output logic [NPORTS-1:0]      s_cyc,
    output logic [NPORTS-1:0]      s_stb,
    output logic                   s_we,
    output logic [DW/8-1:0]        s_sel,
    output logic [AW-1:0]          s_adr,
    output logic [DW-1:0]          s_dat_o,
    input  logic [NPORTS*DW-1:0]   s_dat_i,
    input  logic [NPORTS-1:0]      s_ack,
    input  logic [NPORTS-1:0]      s_err,
    input  logic [NPORTS-1:0]      s_stall,
    output logic                   timeout_o
);

    localparam int OW = $clog2(MAXOUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, UNMAP, ERR} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     act, act_n;
    logic [OW-1:0]     outs, outs_n;
    logic [TW-1:0]     timer, timer_n;
    logic              epend, epend_n;
    logic [REGION_BITS-1:0] region;
    logic [PW-1:0]     hit_idx;
    logic              any_hit;
    logic              accept, resp, same;
    logic [DW-1:0]     sdat [NPORTS];

    assign s_we    = m_we;
    assign s_sel   = m_sel;
    assign s_adr   = m_adr;
    assign s_dat_o = m_dat_i;
    assign region  = m_adr[AW-1 -: REGION_BITS];

    for (genvar g = 0; g < NPORTS; g++) begin : g_dat
        assign sdat[g] = s_dat_i[g*DW +: DW];
    end

    // Scan downwards so the lowest matching port wins.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (region == PORT_MAP[i*REGION_BITS +: REGION_BITS]) begin
                any_hit = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_n   = state;
        act_n     = act;
        outs_n    = outs;
        timer_n   = timer;
        epend_n   = 1'b0;
        s_cyc     = '0;
        s_stb     = '0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        m_stall   = 1'b0;
        m_dat_o   = '0;
        timeout_o = 1'b0;
        accept    = 1'b0;
        resp      = 1'b0;
        same      = any_hit && (hit_idx == act);
        if (rst_i) begin
            state_n = IDLE;
            act_n   = '0;
            outs_n  = '0;
            timer_n = '0;
        end else if (!m_cyc) begin
            state_n = IDLE;
            outs_n  = '0;
            timer_n = '0;
        end else begin
            unique case (state)
                IDLE, UNMAP: begin
                    m_err   = epend;
                    timer_n = '0;
                    if (m_stb && any_hit) begin
                        s_cyc[hit_idx] = 1'b1;
                        s_stb[hit_idx] = 1'b1;
                        m_stall = s_stall[hit_idx];
                        act_n   = hit_idx;
                        state_n = BUSY;
                        outs_n  = OW'(!s_stall[hit_idx]);
                    end else if (m_stb) begin
                        epend_n = 1'b1;
                        state_n = UNMAP;
                    end
                end
                BUSY: begin
                    s_cyc[act] = 1'b1;
                    m_dat_o = sdat[act];
                    if (outs != '0) begin
                        m_ack = s_ack[act];
                        m_err = s_err[act];
                    end
                    resp = m_ack | m_err;
                    if (m_stb && same) begin
                        if (outs == OW'(MAXOUT)) begin
                            m_stall = 1'b1;
                        end else begin
                            s_stb[act] = 1'b1;
                            m_stall = s_stall[act];
                            accept  = !s_stall[act];
                        end
                    end else if (m_stb && outs != '0) begin
                        m_stall = 1'b1;
                    end else if (m_stb && any_hit) begin
                        s_cyc          = '0;
                        s_cyc[hit_idx] = 1'b1;
                        s_stb[hit_idx] = 1'b1;
                        m_stall = s_stall[hit_idx];
                        act_n   = hit_idx;
                        accept  = !s_stall[hit_idx];
                    end else if (m_stb) begin
                        s_cyc   = '0;
                        epend_n = 1'b1;
                        state_n = UNMAP;
                    end
                    outs_n  = outs + OW'(accept) - OW'(resp);
                    timer_n = (outs != '0 && !resp) ? timer + TW'(1) : '0;
                    // Hung slave: abandon the cycle toward it entirely.
                    if (timer == TW'(TIMEOUT)) begin
                        s_cyc     = '0;
                        s_stb     = '0;
                        m_ack     = 1'b0;
                        m_err     = 1'b1;
                        m_stall   = 1'b1;
                        timeout_o = 1'b1;
                        act_n     = act;
                        outs_n    = '0;
                        timer_n   = '0;
                        epend_n   = 1'b0;
                        state_n   = ERR;
                    end
                end
                ERR: m_stall = 1'b1;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            act   <= '0;
            outs  <= '0;
            timer <= '0;
            epend <= 1'b0;
        end else begin
            state <= state_n;
            act   <= act_n;
            outs  <= outs_n;
            timer <= timer_n;
            epend <= epend_n;
        end
    end

endmodule
